// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decode fields, forwards MEM/WB results onto the
// stored operands, selects ALU B, and inserts one bubble on load-use. Optional perf
// counters are enabled with the ID_EX_PERF_EN macro.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [2:0]    id_alu_op,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alu_src,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          mem_fwd_en,
  input  logic [RW-1:0] mem_fwd_rd,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic          wb_fwd_en,
  input  logic [RW-1:0] wb_fwd_rd,
  input  logic [DW-1:0] wb_fwd_data,
  input  logic          ex_ready,
  output logic          ex_valid,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_flush_cnt
`endif
);

  logic          valid_q, valid_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q, imm_d;
  logic          alu_src_q, alu_src_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;

  logic          hazard;
  logic          drain;
  logic          capture;
  logic [DW-1:0] rs_fwd, rt_fwd;

  always_comb begin
    hazard   = valid_q & mem_read_q & (rd_q != '0) & id_valid &
               ((rd_q == id_rs) | (rd_q == id_rt));
    drain    = !valid_q | ex_ready;
    id_ready = drain & !hazard;
    capture  = id_valid & id_ready;
  end

  always_comb begin
    valid_d     = valid_q;
    alu_op_d    = alu_op_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (capture) begin
      valid_d     = 1'b1;
      alu_op_d    = id_alu_op;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = id_imm;
      alu_src_d   = id_alu_src;
      rs_d        = id_rs;
      rt_d        = id_rt;
      rd_d        = id_rd;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
    end else if (drain) begin
      // Nothing to take (or load-use hazard): emit a bubble, keep data fields.
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      alu_op_q    <= 3'b010;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      alu_op_q    <= alu_op_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Forwarding works on the stored indices, so a held instruction keeps tracking newer results.
  always_comb begin
    if (mem_fwd_en && mem_fwd_rd == rs_q && rs_q != '0)     rs_fwd = mem_fwd_data;
    else if (wb_fwd_en && wb_fwd_rd == rs_q && rs_q != '0)  rs_fwd = wb_fwd_data;
    else                                                    rs_fwd = rs_data_q;
    if (mem_fwd_en && mem_fwd_rd == rt_q && rt_q != '0)     rt_fwd = mem_fwd_data;
    else if (wb_fwd_en && wb_fwd_rd == rt_q && rt_q != '0)  rt_fwd = wb_fwd_data;
    else                                                    rt_fwd = rt_data_q;
  end

  assign ex_valid      = valid_q;
  assign alu_op        = alu_op_q;
  assign alu_a         = rs_fwd;
  assign alu_b         = alu_src_q ? imm_q : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q & valid_q;
  assign ex_mem_read   = mem_read_q & valid_q;
  assign ex_mem_write  = mem_write_q & valid_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'b0, hazard};
    flush_cnt_d = flush_cnt_q + {31'b0, flush};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected ALU-side outputs are queued when an
// instruction is driven and popped/compared once the stage presents it.
module tb_id_ex_stage;
  logic        clk, reset, flush, id_valid, id_ready;
  logic [2:0]  id_alu_op;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alu_src;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        mem_fwd_en;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_en;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        ex_ready, ex_valid;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_op(id_alu_op), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
`ifdef ID_EX_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  typedef struct packed {
    logic        v;
    logic [2:0]  op;
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } obs_t;

  obs_t sb[$];
  obs_t e, o;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t cur();
    return '{ex_valid, alu_op, alu_a, alu_b, ex_store_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write};
  endfunction

  function automatic obs_t mk(input logic v, input logic [2:0] op,
                              input logic [31:0] a, b, sd, input logic [4:0] rd,
                              input logic rw, mr, mw);
    return '{v, op, a, b, sd, rd, rw, mr, mw};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rs, rt, rd,
                       input logic [31:0] rsd, rtd, imm,
                       input logic src, rw, mr, mw);
    id_valid = 1; id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_src = src;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic test_reset();
    reset = 1;
    step(); step();
    sb.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 0, 0));
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_state got %h exp %h", o, e); end
    reset = 0;
    step();
    n_tests++;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", id_ready); end
  endtask

  task automatic test_basic();
    drive(3'b010, 1, 2, 3, 32'd5, 32'd7, 32'h0, 0, 1, 0, 0);
    sb.push_back(mk(1, 3'b010, 32'd5, 32'd7, 32'd7, 3, 1, 0, 0));
    step();
    drive(3'b010, 1, 2, 8, 32'd9, 32'd11, 32'hFFFF_FFF0, 1, 1, 0, 0);
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL basic_add got %h exp %h", o, e); end
    sb.push_back(mk(1, 3'b010, 32'd9, 32'hFFFF_FFF0, 32'd11, 8, 1, 0, 0));
    step();
    id_valid = 0;
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL basic_imm got %h exp %h", o, e); end
    step();
  endtask

  task automatic test_forward();
    drive(3'b110, 1, 2, 3, 32'd5, 32'd7, 32'h0, 0, 1, 0, 0);
    step();
    id_valid = 0;
    mem_fwd_en = 1; mem_fwd_rd = 1; mem_fwd_data = 32'd100;
    wb_fwd_en  = 1; wb_fwd_rd  = 1; wb_fwd_data  = 32'd200;
    #1;
    sb.push_back(mk(1, 3'b110, 32'd100, 32'd7, 32'd7, 3, 1, 0, 0));
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL fwd_mem_wins got %h exp %h", o, e); end
    mem_fwd_en = 0; wb_fwd_rd = 2;
    #1;
    sb.push_back(mk(1, 3'b110, 32'd5, 32'd200, 32'd200, 3, 1, 0, 0));
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL fwd_wb_rt got %h exp %h", o, e); end
    wb_fwd_en = 0;
    step();
  endtask

  task automatic test_r0();
    drive(3'b000, 0, 0, 3, 32'd0, 32'd0, 32'h0, 0, 1, 0, 0);
    step();
    id_valid = 0;
    mem_fwd_en = 1; mem_fwd_rd = 0; mem_fwd_data = 32'hDEAD;
    wb_fwd_en  = 1; wb_fwd_rd  = 0; wb_fwd_data  = 32'hBEEF;
    #1;
    sb.push_back(mk(1, 3'b000, 32'd0, 32'd0, 32'd0, 3, 1, 0, 0));
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL r0_no_fwd got %h exp %h", o, e); end
    mem_fwd_en = 0; wb_fwd_en = 0;
    step();
  endtask

  task automatic test_load_use();
    drive(3'b010, 1, 4, 4, 32'h100, 32'h0, 32'd8, 1, 1, 1, 0);
    step();
    drive(3'b010, 4, 1, 5, 32'h999, 32'd3, 32'h0, 0, 1, 0, 0);
    #1;
    n_tests++;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready_low got %b exp 0", id_ready); end
    sb.push_back(mk(1, 3'b010, 32'h100, 32'd8, 32'h0, 4, 1, 1, 0));
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL lu_load got %h exp %h", o, e); end
    step();
    n_tests++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, id_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL lu_bubble got %b exp 00001",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, id_ready});
    end
    step();
    id_valid = 0;
    wb_fwd_en = 1; wb_fwd_rd = 4; wb_fwd_data = 32'h55;
    #1;
    sb.push_back(mk(1, 3'b010, 32'h55, 32'd3, 32'd3, 5, 1, 0, 0));
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL lu_add_fwd got %h exp %h", o, e); end
    wb_fwd_en = 0;
    // load to r0 must not stall
    drive(3'b010, 1, 0, 0, 32'h0, 32'h0, 32'd4, 1, 1, 1, 0);
    step();
    drive(3'b010, 0, 2, 6, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0);
    #1;
    n_tests++;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lu_r0_ready got %b exp 1", id_ready); end
    step();
    id_valid = 0;
    step();
  endtask

  task automatic test_hold_flush();
    drive(3'b110, 2, 3, 6, 32'h10, 32'h20, 32'h0, 0, 1, 0, 0);
    step();
    drive(3'b000, 7, 8, 9, 32'hA, 32'hB, 32'h0, 0, 1, 0, 1);
    ex_ready = 0;
    #1;
    n_tests++;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready got %b exp 0", id_ready); end
    sb.push_back(mk(1, 3'b110, 32'h10, 32'h20, 32'h20, 6, 1, 0, 0));
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL hold_c1 got %h exp %h", o, e); end
    step();
    mem_fwd_en = 1; mem_fwd_rd = 2; mem_fwd_data = 32'h77;
    #1;
    sb.push_back(mk(1, 3'b110, 32'h77, 32'h20, 32'h20, 6, 1, 0, 0));
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL hold_c2_fwd got %h exp %h", o, e); end
    mem_fwd_en = 0;
    flush = 1;
    step();
    flush = 0;
    n_tests++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, id_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL flush_kill got %b exp 00001",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, id_ready});
    end
    step();
    ex_ready = 1; id_valid = 0;
    sb.push_back(mk(1, 3'b000, 32'hA, 32'hB, 32'hB, 9, 1, 0, 1));
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL flush_then_cap got %h exp %h", o, e); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rd;
    logic        src, mw;
    logic [2:0]  op;
    for (int i = 0; i < 6; i++) begin
      rsd = $urandom; rtd = $urandom; imm = $urandom;
      rd = 5'($urandom_range(1, 31)); src = 1'($urandom); mw = 1'($urandom);
      op = 3'($urandom);
      drive(op, 5'd10, 5'd11, rd, rsd, rtd, imm, src, 1, 0, mw);
      if (i > 0) begin
        e = sb.pop_front(); o = cur(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL b2b_%0d got %h exp %h", i - 1, o, e); end
      end
      sb.push_back(mk(1, op, rsd, src ? imm : rtd, rtd, rd, 1, 0, mw));
      step();
    end
    id_valid = 0;
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL b2b_last got %h exp %h", o, e); end
    step();
  endtask

  task automatic test_perf();
`ifdef ID_EX_PERF_EN
    n_tests++;
    if (perf_stall_cnt !== 32'd1) begin n_fail++; $display("FAIL perf_stall got %0d exp 1", perf_stall_cnt); end
    n_tests++;
    if (perf_flush_cnt !== 32'd1) begin n_fail++; $display("FAIL perf_flush got %0d exp 1", perf_flush_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    drive(3'b111, 3, 4, 12, 32'h5, 32'h6, 32'h0, 0, 1, 0, 0);
    step();
    reset = 1;
    step();
    sb.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 0, 0));
    e = sb.pop_front(); o = cur(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_mid got %h exp %h", o, e); end
`ifdef ID_EX_PERF_EN
    n_tests++;
    if ({perf_stall_cnt, perf_flush_cnt} !== 64'd0) begin
      n_fail++; $display("FAIL perf_reset got %h exp 0", {perf_stall_cnt, perf_flush_cnt});
    end
`endif
    reset = 0; id_valid = 0;
    step();
  endtask

  initial begin
    reset = 1; flush = 0; id_valid = 0; id_alu_op = 3'b010;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_src = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    ex_ready = 1;
    test_reset();
    test_basic();
    test_forward();
    test_r0();
    test_load_use();
    test_hold_flush();
    test_back_to_back();
    test_perf();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
